// File: rtl/fitness_sweep_evaluator.sv
// ---------------------------------------------------------------------------
// fitness_sweep_evaluator
//   Sequential truth-table fitness evaluator for evolved combinational
//   candidates. Sweeps all 2^N_IN input vectors into an external candidate
//   circuit, holds each vector SETTLE+1 cycles, samples the candidate output
//   on the last edge of that window and counts output bits that agree with a
//   target table latched when the sweep starts.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   request a sweep (accepted only when idle)
//   abort      in   synchronous cancel of a running sweep
//   target     in   expected table; [v*N_OUT +: N_OUT] is the row for vector v
//   dut_in     out  vector driven to the candidate
//   dut_out    in   candidate response
//   busy       out  high while a sweep runs
//   done       out  one-cycle pulse at sweep completion
//   score      out  number of matching output bits
//   perfect    out  score equals the maximum (valid from done onward)
//   fail_seen  out  at least one vector mismatched
//   first_fail out  lowest mismatching vector index
// ---------------------------------------------------------------------------
module fitness_sweep_evaluator #(
  parameter int N_IN    = 4,
  parameter int N_OUT   = 4,
  parameter int SETTLE  = 2,
  localparam int SCORE_W = $clog2(N_OUT * (1 << N_IN) + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [N_OUT*(1<<N_IN)-1:0]    target,
  output logic [N_IN-1:0]               dut_in,
  input  logic [N_OUT-1:0]              dut_out,
  output logic                          busy,
  output logic                          done,
  output logic [SCORE_W-1:0]            score,
  output logic                          perfect,
  output logic                          fail_seen,
  output logic [N_IN-1:0]               first_fail
);

  localparam int NVEC   = 1 << N_IN;
  localparam int TW     = N_OUT * NVEC;
  // Sized so that SETTLE=0 still gets a 1-bit counter.
  localparam int WAIT_W = $clog2(SETTLE + 2);

  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(TW);
  localparam logic [WAIT_W-1:0]  WAIT_LOAD = WAIT_W'(SETTLE);
  localparam logic [N_IN-1:0]    LAST_VEC  = {N_IN{1'b1}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Number of set bits in a candidate-width word, at score width.
  function automatic logic [SCORE_W-1:0] popcount(input logic [N_OUT-1:0] v);
    logic [SCORE_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_OUT; i++) begin
      c = c + SCORE_W'(v[i]);
    end
    return c;
  endfunction

  logic [1:0]         state_q,   state_d;
  logic [N_IN-1:0]    vec_q,     vec_d;
  logic [WAIT_W-1:0]  wait_q,    wait_d;
  logic [TW-1:0]      tgt_q,     tgt_d;
  logic [SCORE_W-1:0] score_q,   score_d;
  logic               perfect_q, perfect_d;
  logic               fail_q,    fail_d;
  logic [N_IN-1:0]    ffail_q,   ffail_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;

  logic [N_OUT-1:0]   exp_row_s;
  logic [SCORE_W-1:0] hits_s;
  logic               mismatch_s;

  // Compare the candidate response against the latched row of the current vector.
  always_comb begin
    exp_row_s  = tgt_q[int'(vec_q) * N_OUT +: N_OUT];
    hits_s     = popcount(~(dut_out ^ exp_row_s));
    mismatch_s = (dut_out != exp_row_s);
  end

  // Next-state logic for the sweep controller and result registers.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    wait_d    = wait_q;
    tgt_d     = tgt_q;
    score_d   = score_q;
    perfect_d = perfect_q;
    fail_d    = fail_q;
    ffail_d   = ffail_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort takes priority over start on the same edge
        if (!abort && start) begin
          tgt_d     = target;
          vec_d     = '0;
          wait_d    = WAIT_LOAD;
          score_d   = '0;
          perfect_d = 1'b0;
          fail_d    = 1'b0;
          ffail_d   = '0;
          busy_d    = 1'b1;
          state_d   = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (abort) begin
          vec_d     = '0;
          wait_d    = '0;
          score_d   = '0;
          perfect_d = 1'b0;
          fail_d    = 1'b0;
          ffail_d   = '0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else begin
          // Last edge of this vector's window: sample and score.
          score_d = score_q + hits_s;
          if (mismatch_s && !fail_q) begin
            fail_d  = 1'b1;
            ffail_d = vec_q;
          end else begin
            fail_d  = fail_q;
          end
          if (vec_q == LAST_VEC) begin
            // dut_in holds the final vector; counter never wraps.
            perfect_d = (score_d == MAX_SCORE);
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            vec_d  = vec_q + N_IN'(1);
            wait_d = WAIT_LOAD;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      wait_q    <= '0;
      tgt_q     <= '0;
      score_q   <= '0;
      perfect_q <= 1'b0;
      fail_q    <= 1'b0;
      ffail_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      wait_q    <= wait_d;
      tgt_q     <= tgt_d;
      score_q   <= score_d;
      perfect_q <= perfect_d;
      fail_q    <= fail_d;
      ffail_q   <= ffail_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign dut_in     = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign score      = score_q;
  assign perfect    = perfect_q;
  assign fail_seen  = fail_q;
  assign first_fail = ffail_q;

endmodule

// File: doc/fitness_sweep_evaluator.md
Name: fitness_sweep_evaluator

Overview:
- Sequential truth-table fitness evaluator for evolved combinational candidates such as the four-in/four-out gate networks.
- Drives every one of 2^N_IN input vectors into an external candidate circuit and waits a programmable settle time to absorb gate delays.
- Samples the candidate outputs and counts output bits that match a latched target truth table.
- Reports score, a perfect flag and the first failing vector to the evolution controller.

Parameters:
- N_IN, 4, candidate input width; 2^N_IN vectors swept.
- N_OUT, 4, candidate output width.
- SETTLE, 2, extra wait cycles per vector before sampling (0 allowed).
- SCORE_W (localparam), clog2(N_OUT*2^N_IN + 1), score width; 7 at defaults.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep; accepted only in IDLE.
- abort  input  1  synchronous cancel of a running sweep.
- target  input  N_OUT*2^N_IN  expected table; bits [v*N_OUT +: N_OUT] are the expected outputs for input vector v.
- dut_in  output  N_IN  vector driven to the candidate.
- dut_out  input  N_OUT  candidate response.
- busy  output  1  high while a sweep runs.
- done  output  1  one-cycle pulse when a sweep completes.
- score  output  SCORE_W  count of matching output bits.
- perfect  output  1  score == N_OUT*2^N_IN; valid from done onward.
- fail_seen  output  1  at least one vector mismatched.
- first_fail  output  N_IN  lowest mismatching vector index.

Behaviour:
- Reset (async, any state): state IDLE; dut_in=0, busy=0, done=0, score=0, perfect=0, fail_seen=0, first_fail=0; vector and wait counters 0.
- States: IDLE, WAIT, DONE.
- IDLE, start=1 at an edge:
  - target latched internally; later target changes have no effect on this sweep.
  - vec=0, dut_in=0, wait=SETTLE.
  - score, fail_seen, first_fail and perfect cleared; busy=1; go to WAIT.
- WAIT, each edge with wait!=0: wait decrements; dut_in held.
- WAIT, edge with wait==0: sample dut_out.
  - score += popcount(~(dut_out ^ tgt[vec])).
  - If any bit differs and fail_seen==0: fail_seen=1, first_fail=vec.
  - If vec==2^N_IN-1: go to DONE.
  - Otherwise vec++, dut_in=vec+1, wait=SETTLE.
- Per-vector timing: each vector is held exactly SETTLE+1 cycles. dut_out is sampled on the last edge of that window.
- DONE (one cycle): done=1, busy=0, perfect=(score==max); next edge returns to IDLE with done=0.
- Latency: done goes high 2^N_IN*(SETTLE+1) edges after the start edge; 48 at defaults.
- Results hold in IDLE until the next accepted start.
- start while busy (WAIT or DONE): ignored; no restart, no queueing.
- abort=1 in WAIT:
  - Next edge goes to IDLE: busy=0, no done pulse.
  - score, fail_seen, first_fail and perfect cleared; dut_in=0.
- abort in IDLE or DONE: no effect; DONE still pulses.
- abort and start in the same IDLE edge: abort wins; start is not accepted.
- Score accumulator cannot overflow: SCORE_W covers the maximum. The vector counter does not wrap past 2^N_IN-1.
- dut_in changes only on clock edges. The candidate is purely combinational; SETTLE must cover its worst-case path.

Test Plan:
- Defaults; target slice v = v; dut_out wired to dut_in; start pulse -> done exactly 48 cycles later, score=64, perfect=1, fail_seen=0; dut_in steps 0..15, each held 3 cycles.
- Same target; dut_out = ~dut_in -> score=0, perfect=0, fail_seen=1, first_fail=0.
- Same target; dut_out = dut_in with bit1 forced 0 -> score=56, fail_seen=1, first_fail=2.
- SETTLE=0, N_IN=3, N_OUT=2, target all zeros, dut_out tied 0 -> done 8 cycles after start, score=16, perfect=1.
- Two sub-cases:
  - start pulsed at vector 5 -> ignored.
  - abort asserted while dut_in=5 -> next cycle busy=0, score=0, no done. Fresh start then runs the full 48 cycles normally; changing target mid-run does not alter score.
- Async reset asserted mid-sweep between clock edges -> busy, dut_in, score and done go to 0 immediately. After release, start yields correct results.
